rotary_decoder: RTL and testbench
=================================

ROTARY_DECODER -- requirements
Module: rotary_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 5000, stable cycles required before a debounced input changes (100 us at 50 MHz).
REQ-002 SHALL have parameter DETENT_STEPS, default 4, valid quadrature transitions per mechanical detent.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rotA  input  1  raw encoder channel A, asynchronous to clk, may bounce.
REQ-006 SHALL have port rotB  input  1  raw encoder channel B, asynchronous to clk, may bounce.
REQ-007 SHALL have port rotPush  input  1  raw push-button level, active-high, may bounce.
REQ-008 SHALL have port inc  output  1  one-cycle pulse per clockwise detent; feeds the accumulator's inc.
REQ-009 SHALL have port dec  output  1  one-cycle pulse per counter-clockwise detent; feeds the accumulator's dec.
REQ-010 SHALL have port press  output  1  one-cycle pulse on debounced push-button press.
REQ-011 SHALL have port err  output  1  one-cycle pulse on illegal quadrature jump.

Function
REQ-012 SHALL pass each raw input through a 2-flop synchronizer before any other logic.
REQ-013 SHALL update a debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the count at 0.
REQ-014 SHALL form state AB = {debA, debB}; clockwise sequence 00->01->11->10->00, counter-clockwise the reverse.
REQ-015 SHALL keep signed quarter-step count q (range -DETENT_STEPS..+DETENT_STEPS, saturating): +1 per clockwise transition, -1 per counter-clockwise transition.
REQ-016 SHALL treat a change of both A and B in the same cycle (00<->11, 01<->10) as illegal: err pulses one cycle, q unchanged, AB tracking resynchronizes to the new value.
REQ-017 SHALL, on the cycle AB becomes detent state 00: pulse inc one cycle later if q = +DETENT_STEPS, pulse dec one cycle later if q = -DETENT_STEPS, else no pulse; clear q to 0 in all cases.
REQ-018 SHALL never assert inc and dec in the same cycle; partial rotation with reversal before detent yields no pulse.
REQ-019 SHALL pulse press exactly one cycle after debounced rotPush rises 0->1; no pulse on release; holding gives one pulse only.
REQ-020 SHALL allow press and inc/dec in the same cycle (independent paths).
REQ-021 SHALL have latency from last raw edge to inc/dec of 2 (sync) + DEBOUNCE_CYCLES + 1 (detent) + 1 (register) cycles, all outputs registered.

Reset
REQ-022 SHALL, while reset = 0, force inc, dec, press, err to 0, q to 0, debounce counters to 0, synchronizer flops and debounced levels to 0 (AB = 00 detent).
REQ-023 SHALL, on reset assertion mid-rotation, discard partial q; first detent after release requires a full DETENT_STEPS sequence.
REQ-024 SHALL not produce a spurious press on release of reset with rotPush held high for DEBOUNCE_CYCLES; one press pulse is legal once it debounces.

Structure
REQ-025 SHALL place in shared package: quadrature state constants (00, 01, 11, 10), detent state constant, direction encoding (CW/CCW/NONE/ILLEGAL).
REQ-026 SHALL implement synchronizer+debounce as sub-module debounce_sync (parameter DEBOUNCE_CYCLES), instantiated three times.
REQ-027 SHALL compute direction combinationally from previous/current AB, with q, pulses in a single registered process.

Verification (DEBOUNCE_CYCLES = 4 for sim)
REQ-028 SHALL check: clean CW sequence 00->01->11->10->00, each held 10 cycles -> exactly one inc pulse, 1 cycle wide, 8 cycles after final 00 applied; dec stays 0.
REQ-029 SHALL check: same sequence reversed -> exactly one dec pulse; three consecutive CCW detents -> three dec pulses; inc stays 0.
REQ-030 SHALL check: rotA glitches 1-3 cycles wide at AB = 00 -> no debounced change, no inc/dec/err.
REQ-031 SHALL check: 00->01->11 then 11->01->00 (reversal) -> no inc, no dec, q = 0 afterwards.
REQ-032 SHALL check: AB jump 00->11 in one cycle -> one err pulse, no inc/dec; subsequent clean CW detent -> one inc.
REQ-033 SHALL check: reset low at AB = 11 mid-rotation, release, hold rotPush high 20 cycles -> all outputs 0 during reset, single press pulse after release, no inc/dec.

Source files
------------

// File: rtl/rotary_decoder_pkg.sv
// Shared quadrature encoding for the rotary decoder: Gray-code AB states,
// the detent state and the per-cycle direction classification.
package rotary_decoder_pkg;

  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;

  localparam logic [1:0] DETENT_AB = AB_00;

  typedef enum logic [1:0] {
    DIR_NONE    = 2'd0,
    DIR_CW      = 2'd1,
    DIR_CCW     = 2'd2,
    DIR_ILLEGAL = 2'd3
  } dir_e;

  // Clockwise successor in the Gray sequence 00->01->11->10->00.
  function automatic logic [1:0] cw_next(input logic [1:0] ab);
    return {ab[0], ~ab[1]};
  endfunction

  function automatic dir_e quad_dir(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    dir_e dir;
    if (prev_ab == cur_ab) begin
      dir = DIR_NONE;
    end else if ((prev_ab ^ cur_ab) == 2'b11) begin
      dir = DIR_ILLEGAL;
    end else if (cw_next(prev_ab) == cur_ab) begin
      dir = DIR_CW;
    end else begin
      dir = DIR_CCW;
    end
    return dir;
  endfunction

endpackage

// File: rtl/rotary_decoder_debounce_sync.sv
// Two-flop synchronizer followed by a stability-count debouncer: the output
// level follows the input only after it has disagreed for DEBOUNCE_CYCLES cycles.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/rotary_decoder.sv
// Rotary encoder front end: debounced quadrature turned into one-cycle detent
// pulses, plus a debounced push-button press pulse and an illegal-jump pulse.
module rotary_decoder
  import rotary_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int DETENT_STEPS    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rotA,
  input  logic rotB,
  input  logic rotPush,
  output logic inc,
  output logic dec,
  output logic press,
  output logic err
);

  localparam int Q_W = $clog2(DETENT_STEPS + 1) + 1;
  localparam logic signed [Q_W-1:0] Q_MAX  = Q_W'(DETENT_STEPS);
  localparam logic signed [Q_W-1:0] Q_MIN  = Q_W'(-DETENT_STEPS);
  localparam logic signed [Q_W-1:0] Q_ONE  = Q_W'(1);
  localparam logic signed [Q_W-1:0] Q_ZERO = '0;

  logic deb_a;
  logic deb_b;
  logic deb_push;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (rotA),
    .level_o (deb_a)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (rotB),
    .level_o (deb_b)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_push (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (rotPush),
    .level_o (deb_push)
  );

  logic [1:0]           ab_cur;
  logic [1:0]           ab_q;
  logic signed [Q_W-1:0] q_q;
  logic signed [Q_W-1:0] q_d;
  logic signed [Q_W-1:0] q_step;
  dir_e                 dir;
  logic                 detent_arrive;
  logic                 inc_pend_q, inc_pend_d;
  logic                 dec_pend_q, dec_pend_d;
  logic                 err_pend_q, err_pend_d;
  logic                 push_prev_q;
  logic                 inc_q, dec_q, press_q, err_q;
  logic                 press_d;

  assign ab_cur = {deb_a, deb_b};

  // Quarter steps saturate; landing on the detent decides the pulse and
  // clears the count. Detent pulses are staged once more before the output.
  always_comb begin
    dir           = quad_dir(ab_q, ab_cur);
    q_step        = q_q;
    detent_arrive = 1'b0;
    q_d           = q_q;
    inc_pend_d    = 1'b0;
    dec_pend_d    = 1'b0;
    err_pend_d    = 1'b0;
    press_d       = deb_push & ~push_prev_q;

    case (dir)
      DIR_CW:      if (q_q < Q_MAX) q_step = q_q + Q_ONE;
      DIR_CCW:     if (q_q > Q_MIN) q_step = q_q - Q_ONE;
      DIR_ILLEGAL: err_pend_d = 1'b1;
      default:     q_step = q_q;
    endcase

    detent_arrive = (dir != DIR_NONE) && (ab_cur == DETENT_AB);
    if (detent_arrive) begin
      q_d        = Q_ZERO;
      inc_pend_d = (dir == DIR_CW)  && (q_step == Q_MAX);
      dec_pend_d = (dir == DIR_CCW) && (q_step == Q_MIN);
    end else begin
      q_d = q_step;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ab_q        <= DETENT_AB;
      q_q         <= Q_ZERO;
      inc_pend_q  <= 1'b0;
      dec_pend_q  <= 1'b0;
      err_pend_q  <= 1'b0;
      push_prev_q <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      press_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ab_q        <= ab_cur;
      q_q         <= q_d;
      inc_pend_q  <= inc_pend_d;
      dec_pend_q  <= dec_pend_d;
      err_pend_q  <= err_pend_d;
      push_prev_q <= deb_push;
      inc_q       <= inc_pend_q;
      dec_q       <= dec_pend_q;
      press_q     <= press_d;
      err_q       <= err_pend_q;
    end
  end

  assign inc   = inc_q;
  assign dec   = dec_q;
  assign press = press_q;
  assign err   = err_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder with a short debounce window.
module tb_rotary_decoder;

  localparam int DEB   = 4;
  localparam int STEPS = 4;

  logic clk = 1'b0;
  logic reset;
  logic rotA;
  logic rotB;
  logic rotPush;
  logic inc;
  logic dec;
  logic press;
  logic err;

  int n_cmp  = 0;
  int n_fail = 0;

  int inc_cnt   = 0;
  int dec_cnt   = 0;
  int press_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int inc0, dec0, press0, err0;

  always #5 clk = ~clk;

  rotary_decoder #(
    .DEBOUNCE_CYCLES (DEB),
    .DETENT_STEPS    (STEPS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rotA    (rotA),
    .rotB    (rotB),
    .rotPush (rotPush),
    .inc     (inc),
    .dec     (dec),
    .press   (press),
    .err     (err)
  );

  // High-cycle counters sampled just after each rising edge.
  always @(posedge clk) begin
    #2;
    if (inc)         inc_cnt++;
    if (dec)         dec_cnt++;
    if (press)       press_cnt++;
    if (err)         err_cnt++;
    if (inc && dec)  both_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mark();
    inc0   = inc_cnt;
    dec0   = dec_cnt;
    press0 = press_cnt;
    err0   = err_cnt;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input logic [1:0] ab, input int n);
    rotA = ab[1];
    rotB = ab[0];
    hold(n);
  endtask

  task automatic rot_cw();
    set_ab(2'b01, 10);
    set_ab(2'b11, 10);
    set_ab(2'b10, 10);
    set_ab(2'b00, 10);
  endtask

  task automatic rot_ccw();
    set_ab(2'b10, 10);
    set_ab(2'b11, 10);
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
  endtask

  initial begin
    reset   = 1'b0;
    rotA    = 1'b0;
    rotB    = 1'b0;
    rotPush = 1'b0;
    @(negedge clk);
    hold(4);

    // Reset state
    check("rst_inc",   inc,   0);
    check("rst_dec",   dec,   0);
    check("rst_press", press, 0);
    check("rst_err",   err,   0);
    check("rst_q",     dut.q_q, 0);
    reset = 1'b1;
    hold(10);

    // Clean clockwise detent with exact pulse timing
    mark();
    set_ab(2'b01, 10);
    set_ab(2'b11, 10);
    set_ab(2'b10, 10);
    rotA = 1'b0;
    rotB = 1'b0;
    hold(7);
    check("cw_inc_t7", inc, 0);
    hold(1);
    check("cw_inc_t8", inc, 1);
    hold(1);
    check("cw_inc_t9", inc, 0);
    hold(1);
    check("cw_inc_count", inc_cnt - inc0, 1);
    check("cw_dec_count", dec_cnt - dec0, 0);
    check("cw_err_count", err_cnt - err0, 0);

    // Counter-clockwise: one detent, then three in a row
    mark();
    rot_ccw();
    check("ccw1_dec_count", dec_cnt - dec0, 1);
    check("ccw1_inc_count", inc_cnt - inc0, 0);
    mark();
    repeat (3) rot_ccw();
    check("ccw3_dec_count", dec_cnt - dec0, 3);
    check("ccw3_inc_count", inc_cnt - inc0, 0);

    // Short glitches on A at the detent must not get through
    mark();
    for (int w = 1; w <= 3; w++) begin
      rotA = 1'b1;
      hold(w);
      rotA = 1'b0;
      hold(10);
      check("glitch_ab", dut.ab_q, 0);
    end
    check("glitch_inc", inc_cnt - inc0, 0);
    check("glitch_dec", dec_cnt - dec0, 0);
    check("glitch_err", err_cnt - err0, 0);

    // Partial rotation then reversal back to the detent
    mark();
    set_ab(2'b01, 10);
    set_ab(2'b11, 10);
    check("rev_q_at_11", dut.q_q, 2);
    set_ab(2'b01, 10);
    check("rev_q_at_01", dut.q_q, 1);
    set_ab(2'b00, 10);
    check("rev_q_at_00", dut.q_q, 0);
    check("rev_inc", inc_cnt - inc0, 0);
    check("rev_dec", dec_cnt - dec0, 0);

    // Illegal jump 00->11, half detent back to 00, then a clean detent
    mark();
    set_ab(2'b11, 10);
    check("ill_err_count", err_cnt - err0, 1);
    check("ill_q", dut.q_q, 0);
    set_ab(2'b10, 10);
    set_ab(2'b00, 10);
    check("ill_inc", inc_cnt - inc0, 0);
    check("ill_dec", dec_cnt - dec0, 0);
    mark();
    rot_cw();
    check("ill_then_cw_inc", inc_cnt - inc0, 1);
    check("ill_then_cw_err", err_cnt - err0, 0);

    // Reset in the middle of a rotation with the button held
    set_ab(2'b01, 10);
    set_ab(2'b11, 10);
    check("mid_q_before_rst", dut.q_q, 2);
    mark();
    reset   = 1'b0;
    rotPush = 1'b1;
    rotA    = 1'b0;
    rotB    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hold(1);
      check("mid_rst_outs", {inc, dec, press, err}, 0);
    end
    check("mid_rst_q", dut.q_q, 0);
    reset = 1'b1;
    hold(20);
    check("post_rst_press", press_cnt - press0, 1);
    check("post_rst_inc",   inc_cnt - inc0, 0);
    check("post_rst_dec",   dec_cnt - dec0, 0);
    check("post_rst_err",   err_cnt - err0, 0);
    rotPush = 1'b0;
    hold(10);
    check("release_no_press", press_cnt - press0, 1);
    mark();
    rot_cw();
    check("post_rst_cw_inc", inc_cnt - inc0, 1);

    // Press timing and press coinciding with an inc pulse
    mark();
    set_ab(2'b01, 10);
    set_ab(2'b11, 10);
    set_ab(2'b10, 10);
    rotA = 1'b0;
    rotB = 1'b0;
    hold(1);
    rotPush = 1'b1;
    hold(6);
    check("co_press_t6", press, 0);
    check("co_inc_t7",   inc,   0);
    hold(1);
    check("co_press_t7", press, 1);
    check("co_inc_t8",   inc,   1);
    hold(1);
    check("co_press_t8", press, 0);
    check("co_inc_t9",   inc,   0);
    hold(10);
    rotPush = 1'b0;
    hold(10);
    check("co_press_count", press_cnt - press0, 1);
    check("co_inc_count",   inc_cnt - inc0, 1);

    check("never_inc_and_dec", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
